axi4_wr_agent: RTL and testbench
================================

# axi4_wr_agent

AXI4 write-channel responder: accepts AW/W/B traffic from an AXI4 write host and converts each burst into a sequence of single-cycle word writes on a simple memory-style port. It sits between an `axi4_wr_intf`-style host (DMA, interconnect) and on-chip RAM or register storage. One burst is outstanding at a time; FIXED, INCR and WRAP bursts are supported, with SLVERR reporting for illegal requests.

## Interface
- DWIDTH, 512, data width in bits (power of two, ≥ 8)
- AWIDTH, 32, byte address width
- IDWIDTH, 4, transaction ID width
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- aid  in  IDWIDTH  write address ID
- aaddr  in  AWIDTH  start byte address
- alen  in  8  beats minus one
- asize  in  3  log2 bytes per beat
- aburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- avalid  in  1  address valid
- aready  out  1  address ready
- data  in  DWIDTH  write data
- strb  in  DWIDTH/8  byte strobes
- last  in  1  last beat marker
- valid  in  1  write data valid
- ready  out  1  write data ready
- bid  out  IDWIDTH  response ID (= captured aid)
- resp  out  2  00 OKAY, 10 SLVERR
- bvalid  out  1  response valid
- bready  in  1  response ready
- mem_we  out  1  one-cycle write strobe
- mem_addr  out  AWIDTH  beat byte address, low log2(DWIDTH/8) bits forced 0
- mem_wdata  out  DWIDTH  registered beat data
- mem_be  out  DWIDTH/8  registered beat strobes

## Operation
- FSM: IDLE → DATA → RESP → IDLE.
- IDLE: aready=1, ready=0. On avalid&aready capture aid, aaddr, alen, asize, aburst; clear beat counter and error flag; go DATA.
- Request checks at capture (any failure sets err, suppresses all mem_we for the burst, data still consumed):
  - aburst=11;
  - asize > log2(DWIDTH/8);
  - WRAP with alen not in {1,3,7,15}, or aaddr not aligned to 2^asize.
- DATA: ready=1. Each valid&ready beat: register data/strb into mem_wdata/mem_be, pulse mem_we (unless err), update address, increment counter.
- Address update: FIXED unchanged; INCR addr += 2^asize (wraps modulo 2^AWIDTH, no 4 KB check); WRAP addr = boundary + ((addr + 2^asize) mod (2^asize·(alen+1))), boundary = aaddr rounded down to 2^asize·(alen+1).
- Beat count governs termination: burst ends on beat alen+1 regardless of last. last=0 on final beat, or last=1 on an earlier beat, sets err (writes already issued stay issued). After final beat go RESP.
- RESP: bvalid=1, bid=captured aid, resp=err?10:00; hold stable until bready. On bvalid&bready go IDLE.
- Strobes passed through unmodified; narrow-transfer lane selection is the host's responsibility.

## Timing
- Reset values: aready=0, ready=0, bvalid=0, bid=0, resp=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0; FSM=IDLE. aready rises the first cycle after rst deasserts.
- AW handshake in cycle n → aready=0, ready=1 in cycle n+1.
- W beat handshake in cycle n → mem_we=1 with that beat's address/data/strobes in cycle n+1 (one cycle only).
- Throughput: one beat per cycle while valid held high; alen=255 completes in 256 consecutive cycles.
- Final beat handshake in cycle n → ready=0, bvalid=1 in cycle n+1.
- B handshake in cycle n → bvalid=0, aready=1 in cycle n+1. Minimum burst turnaround: AW→B for a single beat = 2 cycles plus bready wait.
- W data presented before AW is not accepted (ready=0 in IDLE); avalid during DATA/RESP is stalled.
- rst asserted mid-burst: next cycle all outputs at reset values, remaining beats dropped, no response issued.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- INCR, aaddr=0x100, alen=3, asize=6 (DWIDTH=512), 4 back-to-back beats → mem_we at addresses 0x100,0x140,0x180,0x1C0 one cycle after each beat; bvalid with resp=00, bid=aid.
- WRAP, aaddr=0x0C0, alen=3, asize=6 → addresses 0x0C0,0x000,0x040,0x080; resp=00.
- FIXED, aaddr=0x40, alen=2, valid toggling every other cycle → three writes all at 0x40, each one cycle after its handshake.
- aburst=11, alen=1 → 2 beats accepted, mem_we never asserted, resp=10.
- INCR alen=3 with last=1 on beat 2 → all 4 beats written, resp=10; bready held low 5 cycles → bvalid/bid/resp stable, aready=0 until handshake.
- rst pulsed after beat 1 of an 8-beat burst → outputs at reset values next cycle, no bvalid; new 1-beat burst afterwards completes with resp=00.

Source files
------------

// File: rtl/axi4_wr_agent.sv
// AXI4 write-channel responder.
// Each AW/W burst becomes a run of single-cycle word writes on a memory-style
// port, followed by one B response. Only one burst is in flight at a time.
//
// state  | meaning
// IDLE   | aready high, waiting for a write address
// DATA   | ready high, consuming beats and issuing mem writes
// RESP   | bvalid high, holding bid/resp until bready
module axi4_wr_agent #(
  parameter int DWIDTH  = 512,
  parameter int AWIDTH  = 32,
  parameter int IDWIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDWIDTH-1:0]  aid,
  input  logic [AWIDTH-1:0]   aaddr,
  input  logic [7:0]          alen,
  input  logic [2:0]          asize,
  input  logic [1:0]          aburst,
  input  logic                avalid,
  output logic                aready,
  input  logic [DWIDTH-1:0]   data,
  input  logic [DWIDTH/8-1:0] strb,
  input  logic                last,
  input  logic                valid,
  output logic                ready,
  output logic [IDWIDTH-1:0]  bid,
  output logic [1:0]          resp,
  output logic                bvalid,
  input  logic                bready,
  output logic                mem_we,
  output logic [AWIDTH-1:0]   mem_addr,
  output logic [DWIDTH-1:0]   mem_wdata,
  output logic [DWIDTH/8-1:0] mem_be
);

  localparam int NBYTES = DWIDTH / 8;
  localparam int LSB    = $clog2(NBYTES);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

  state_t              r_state;
  logic [IDWIDTH-1:0]  r_id;
  logic [AWIDTH-1:0]   r_addr;
  logic [AWIDTH-1:0]   r_size_b;
  logic [AWIDTH-1:0]   r_wrap_mask;
  logic [7:0]          r_len;
  logic [7:0]          r_cnt;
  logic [1:0]          r_burst;
  logic                r_req_err;
  logic                r_err;
  logic                r_aready;
  logic                r_ready;
  logic                r_bvalid;
  logic [IDWIDTH-1:0]  r_bid;
  logic [1:0]          r_resp;
  logic                r_mem_we;
  logic [AWIDTH-1:0]   r_mem_addr;
  logic [DWIDTH-1:0]   r_mem_wdata;
  logic [DWIDTH/8-1:0] r_mem_be;

  logic [AWIDTH-1:0]   w_size_b;
  logic [AWIDTH-1:0]   w_wrap_mask;
  logic                w_wrap_len_ok;
  logic                w_req_err;
  logic [AWIDTH-1:0]   w_addr_next;
  logic [AWIDTH-1:0]   w_beat_addr;
  logic                w_final;
  logic                w_last_err;

  // Request decode on the incoming AW fields. Legal WRAP lengths are all-ones
  // values, so the wrap window mask is (alen << asize) | (size - 1).
  assign w_size_b      = AWIDTH'(1) << asize;
  assign w_wrap_mask   = (AWIDTH'(alen) << asize) | (w_size_b - AWIDTH'(1));
  assign w_wrap_len_ok = (alen == 8'd1) || (alen == 8'd3) || (alen == 8'd7) || (alen == 8'd15);
  assign w_req_err     = (aburst == 2'b11)
                      || (32'(asize) > LSB)
                      || ((aburst == 2'b10) &&
                          (!w_wrap_len_ok || ((aaddr & (w_size_b - AWIDTH'(1))) != '0)));

  // Next beat address for the captured burst type.
  always_comb begin
    w_addr_next = r_addr;
    case (r_burst)
      2'b01:   w_addr_next = r_addr + r_size_b;
      2'b10:   w_addr_next = (r_addr & ~r_wrap_mask) | ((r_addr + r_size_b) & r_wrap_mask);
      default: w_addr_next = r_addr;
    endcase
  end

  assign w_beat_addr = r_addr & ~AWIDTH'(NBYTES - 1);
  assign w_final     = (r_cnt == r_len);
  // last must be high on exactly the final beat; anything else flags the burst.
  assign w_last_err  = w_final ? !last : last;

  // Burst FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_id        <= '0;
      r_addr      <= '0;
      r_size_b    <= '0;
      r_wrap_mask <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_burst     <= '0;
      r_req_err   <= 1'b0;
      r_err       <= 1'b0;
      r_aready    <= 1'b0;
      r_ready     <= 1'b0;
      r_bvalid    <= 1'b0;
      r_bid       <= '0;
      r_resp      <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (avalid && r_aready) begin
            r_id        <= aid;
            r_addr      <= aaddr;
            r_size_b    <= w_size_b;
            r_wrap_mask <= w_wrap_mask;
            r_len       <= alen;
            r_burst     <= aburst;
            r_cnt       <= '0;
            r_req_err   <= w_req_err;
            r_err       <= w_req_err;
            r_aready    <= 1'b0;
            r_ready     <= 1'b1;
            r_state     <= S_DATA;
          end else begin
            r_aready <= 1'b1;
          end
        end
        S_DATA: begin
          if (valid && r_ready) begin
            r_mem_wdata <= data;
            r_mem_be    <= strb;
            r_mem_addr  <= w_beat_addr;
            // A bad request drops every write; a misplaced last only flags.
            r_mem_we    <= !r_req_err;
            r_addr      <= w_addr_next;
            r_cnt       <= r_cnt + 8'd1;
            if (w_last_err) r_err <= 1'b1;
            if (w_final) begin
              r_ready  <= 1'b0;
              r_bvalid <= 1'b1;
              r_bid    <= r_id;
              r_resp   <= (r_err || w_last_err) ? 2'b10 : 2'b00;
              r_state  <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (r_bvalid && bready) begin
            r_bvalid <= 1'b0;
            r_aready <= 1'b1;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign aready    = r_aready;
  assign ready     = r_ready;
  assign bvalid    = r_bvalid;
  assign bid       = r_bid;
  assign resp      = r_resp;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;

endmodule

// File: tb/tb_axi4_wr_agent.sv
// Randomized scoreboard bench for axi4_wr_agent (DWIDTH=512, AWIDTH=32).
module tb_axi4_wr_agent;

  localparam int DW = 512;
  localparam int AW = 32;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] aid;
  logic [AW-1:0] aaddr;
  logic [7:0]    alen;
  logic [2:0]    asize;
  logic [1:0]    aburst;
  logic          avalid;
  logic          aready;
  logic [DW-1:0] data;
  logic [DW/8-1:0] strb;
  logic          last;
  logic          valid;
  logic          ready;
  logic [IW-1:0] bid;
  logic [1:0]    resp;
  logic          bvalid;
  logic          bready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW/8-1:0] mem_be;

  axi4_wr_agent #(.DWIDTH(DW), .AWIDTH(AW), .IDWIDTH(IW)) dut (
    .clk(clk), .rst(rst), .aid(aid), .aaddr(aaddr), .alen(alen), .asize(asize),
    .aburst(aburst), .avalid(avalid), .aready(aready), .data(data), .strb(strb),
    .last(last), .valid(valid), .ready(ready), .bid(bid), .resp(resp),
    .bvalid(bvalid), .bready(bready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] be;
  } wexp_t;

  typedef struct {
    logic [IW-1:0] id;
    logic [1:0]    rsp;
  } bexp_t;

  wexp_t exp_w[$];
  bexp_t exp_b[$];

  int checks = 0;
  int errors = 0;
  int g_beat_cycles;
  bit prev_hs = 1'b0;

  task automatic chk(input bit ok, input string name, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // Reference rules written directly from the burst definitions.
  function automatic bit req_illegal(input logic [1:0] b, input int len,
                                     input int size, input logic [AW-1:0] a);
    if (b == 2'b11) return 1'b1;
    if (size > 6) return 1'b1;
    if (b == 2'b10) begin
      if (!(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b1;
      if ((longint'(a) % (longint'(1) << size)) != 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [AW-1:0] start,
                                              input logic [1:0] b, input int len, input int size);
    longint sz, total, boundary, nxt;
    sz = longint'(1) << size;
    case (b)
      2'b01: nxt = (longint'(a) + sz) % (longint'(1) << AW);
      2'b10: begin
        total    = sz * (len + 1);
        boundary = (longint'(start) / total) * total;
        nxt      = boundary + ((longint'(a) + sz) % total);
      end
      default: nxt = longint'(a);
    endcase
    return nxt[AW-1:0];
  endfunction

  // Monitor: pops expected writes / responses whenever the DUT presents them.
  always @(negedge clk) begin
    wexp_t w;
    bexp_t b;
    if (mem_we) begin
      if (exp_w.size() == 0) begin
        chk(1'b0, "spurious_mem_we", $sformatf("got addr %h with no write expected", mem_addr));
      end else begin
        w = exp_w.pop_front();
        chk(mem_addr == w.addr, "mem_addr", $sformatf("got %h want %h", mem_addr, w.addr));
        chk(mem_wdata == w.wdata, "mem_wdata", $sformatf("got %h want %h", mem_wdata, w.wdata));
        chk(mem_be == w.be, "mem_be", $sformatf("got %h want %h", mem_be, w.be));
        chk(prev_hs, "mem_we_latency", "mem_we not one cycle after a beat handshake");
      end
    end
    if (bvalid) begin
      if (exp_b.size() == 0) begin
        chk(1'b0, "spurious_bvalid", $sformatf("got bid %h resp %b with none expected", bid, resp));
      end else begin
        b = exp_b[0];
        chk(bid == b.id, "bid", $sformatf("got %h want %h", bid, b.id));
        chk(resp == b.rsp, "resp", $sformatf("got %b want %b", resp, b.rsp));
        chk(!ready, "ready_in_resp", $sformatf("got %b want 0", ready));
        if (bready) void'(exp_b.pop_front());
      end
    end
    prev_hs = valid && ready && !rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one complete burst. bad_last: beat index whose last flag is inverted
  // (-1 none). gap: 0 back-to-back, 1 idle after every beat, 2 random idles.
  // rst_after: beat index after which reset is pulsed (-1 none).
  task automatic run_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                           input int size, input logic [1:0] b, input int bad_last,
                           input int gap, input int bwait, input int rst_after);
    bit illegal, lasterr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW/8-1:0] s;
    bexp_t be;
    int t;
    illegal = req_illegal(b, len, size, addr);
    lasterr = 1'b0;
    aid = id; aaddr = addr; alen = 8'(len); asize = 3'(size); aburst = b; avalid = 1'b1;
    t = 0;
    while (!aready && t < 50) begin tick(); t++; end
    if (!aready) chk(1'b0, "aw_timeout", "aready never rose");
    tick();
    avalid = 1'b0;
    chk(ready && !aready, "aw_to_w", $sformatf("got ready %b aready %b want 1 0", ready, aready));
    a = addr;
    g_beat_cycles = 0;
    for (int k = 0; k <= len; k++) begin
      for (int j = 0; j < DW / 32; j++) d[j*32 +: 32] = $urandom;
      s = {$urandom, $urandom};
      data = d; strb = s;
      last = (k == len);
      if (k == bad_last) begin last = !last; lasterr = 1'b1; end
      valid = 1'b1;
      if (!illegal) exp_w.push_back('{addr: a & ~32'h3F, wdata: d, be: s});
      t = 0;
      while (!ready && t < 50) begin tick(); t++; g_beat_cycles++; end
      if (!ready) chk(1'b0, "w_timeout", "ready never rose");
      tick();
      g_beat_cycles++;
      valid = 1'b0; last = 1'b0;
      a = next_addr(a, addr, b, len, size);
      if (k == rst_after) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk({aready, ready, bvalid, mem_we} == 4'b0 && bid == '0 && resp == '0 &&
            mem_addr == '0 && mem_wdata == '0 && mem_be == '0,
            "mid_burst_reset", "outputs not at reset values");
        repeat (3) tick();
        return;
      end
      if (k == len) begin
        be.id = id;
        be.rsp = (illegal || lasterr) ? 2'b10 : 2'b00;
        exp_b.push_back(be);
        chk(!ready && bvalid, "final_to_b", $sformatf("got ready %b bvalid %b want 0 1", ready, bvalid));
      end else if (gap == 1) begin
        tick(); g_beat_cycles++;
      end else if (gap == 2) begin
        repeat ($urandom_range(0, 2)) begin tick(); g_beat_cycles++; end
      end
    end
    if (gap == 0)
      chk(g_beat_cycles == len + 1, "throughput",
          $sformatf("got %0d cycles want %0d", g_beat_cycles, len + 1));
    repeat (bwait) begin
      tick();
      chk(bvalid && !aready, "b_hold", $sformatf("got bvalid %b aready %b want 1 0", bvalid, aready));
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk(!bvalid && aready, "b_to_idle", $sformatf("got bvalid %b aready %b want 0 1", bvalid, aready));
    chk(exp_w.size() == 0, "writes_drained", $sformatf("%0d expected writes left", exp_w.size()));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, size, bl, r;
    logic [1:0] b;
    logic [AW-1:0] a;
    rst = 1'b1; aid = '0; aaddr = '0; alen = '0; asize = '0; aburst = '0; avalid = 1'b0;
    data = '0; strb = '0; last = 1'b0; valid = 1'b0; bready = 1'b0;
    repeat (3) tick();
    chk({aready, ready, bvalid, mem_we} == 4'b0 && bid == '0 && resp == '0 &&
        mem_addr == '0 && mem_wdata == '0 && mem_be == '0, "reset_values", "outputs not zero in reset");
    rst = 1'b0;
    chk(!aready, "aready_in_reset", $sformatf("got %b want 0", aready));
    tick();
    chk(aready, "aready_after_reset", $sformatf("got %b want 1", aready));

    // W data before AW must not be accepted.
    valid = 1'b1;
    repeat (3) begin
      tick();
      chk(!ready, "w_before_aw", $sformatf("got ready %b want 0", ready));
    end
    valid = 1'b0;
    tick();

    run_burst(4'h5, 32'h100, 3, 6, 2'b01, -1, 0, 0, -1);
    run_burst(4'h6, 32'h0C0, 3, 6, 2'b10, -1, 0, 1, -1);
    run_burst(4'h7, 32'h040, 2, 6, 2'b00, -1, 1, 0, -1);
    run_burst(4'h8, 32'h000, 1, 6, 2'b11, -1, 0, 0, -1);
    run_burst(4'h9, 32'h200, 3, 6, 2'b01, 1, 0, 5, -1);
    run_burst(4'hA, 32'h300, 7, 6, 2'b01, -1, 0, 0, 0);
    run_burst(4'hB, 32'h400, 0, 6, 2'b01, -1, 0, 0, -1);
    run_burst(4'hC, 32'hFFFF_FF80, 255, 6, 2'b01, -1, 0, 0, -1);
    run_burst(4'hD, 32'h0C4, 3, 2, 2'b10, -1, 0, 0, -1);
    run_burst(4'hE, 32'h0C0, 2, 6, 2'b10, -1, 0, 0, -1);
    run_burst(4'hF, 32'h000, 0, 7, 2'b01, -1, 0, 0, -1);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      b = (r == 0) ? 2'b11 : 2'(r % 3);
      size = ($urandom_range(0, 9) == 0) ? 7 : $urandom_range(0, 6);
      a = $urandom;
      if (b == 2'b10 && $urandom_range(0, 7) != 0) begin
        r = $urandom_range(0, 3);
        len = (r == 0) ? 1 : (r == 1) ? 3 : (r == 2) ? 7 : 15;
        if (size <= 6) a = a & ~((32'd1 << size) - 32'd1);
      end else begin
        len = $urandom_range(0, 15);
      end
      bl = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1;
      run_burst(4'($urandom), a, len, size, b, bl, 2 * $urandom_range(0, 1),
                $urandom_range(0, 3), -1);
    end

    repeat (3) tick();
    chk(exp_w.size() == 0 && exp_b.size() == 0, "queues_empty",
        $sformatf("writes left %0d responses left %0d", exp_w.size(), exp_b.size()));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
